// File: rtl/obs_mul_pkg.sv
// ============================================================================
// obs_mul_pkg : shared constants, FSM state type and operand split helpers
// Revision    : 1.0
// ============================================================================
`default_nettype none

package obs_mul_pkg;

  localparam int W  = 71;
  localparam int H  = 36;
  localparam int D  = 4;
  localparam int PW = 2 * H - 1;
  localparam int ND = H / D;
  localparam int CW = $clog2(ND);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [H-1:0] split_even(input logic [W-1:0] v);
    logic [H-1:0] r;
    for (int k = 0; k < H; k++) r[k] = v[2*k];
    return r;
  endfunction

  // Odd half has one fewer coefficient; its top bit stays zero.
  function automatic logic [H-1:0] split_odd(input logic [W-1:0] v);
    logic [H-1:0] r;
    r = '0;
    for (int k = 0; k < H - 1; k++) r[k] = v[2*k+1];
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gf2_digit_mac.sv
// ============================================================================
// gf2_digit_mac : carry-less H-bit x D-bit digit product XORed into acc << D
// Revision      : 1.0
// ============================================================================
`default_nettype none

module gf2_digit_mac
  import obs_mul_pkg::*;
(
  input  logic [H-1:0]  x,
  input  logic [D-1:0]  digit,
  input  logic [PW-1:0] acc,
  output logic [PW-1:0] acc_next
);

  always_comb begin
    acc_next = acc << D;
    for (int j = 0; j < D; j++) begin
      if (digit[j]) acc_next = acc_next ^ (PW'(x) << j);
    end
  end

endmodule

`default_nettype wire

// File: rtl/obs_split_mul_71bit.sv
// ============================================================================
// obs_split_mul_71bit : even/odd split of two 71-bit GF(2) polynomials and
//                       digit-serial MSB-first computation of the four half
//                       products feeding the OBS overlap stage.
// Optional macro      : OBS_SPLIT_MUL_ZERO_SKIP_EN (early exit on zero tail)
// Revision            : 1.0
// ============================================================================
`default_nettype none

module obs_split_mul_71bit
  import obs_mul_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a_in,
  input  logic [W-1:0]  b_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] p_ee,
  output logic [PW-1:0] p_eo,
  output logic [PW-1:0] p_oe,
  output logic [PW-1:0] p_oo
);

  state_t        state, state_nxt;
  logic [H-1:0]  ae, ao, be, bo;
  logic [PW-1:0] acc_ee, acc_eo, acc_oe, acc_oo;
  logic [PW-1:0] mac_ee, mac_eo, mac_oe, mac_oo;
  logic [CW-1:0] cnt;
  logic [D-1:0]  dig_e, dig_o;
  logic          last;
  logic [6:0]    skip_sh;

  assign dig_e = be[cnt*D +: D];
  assign dig_o = bo[cnt*D +: D];

`ifdef OBS_SPLIT_MUL_ZERO_SKIP_EN
  logic [H-1:0] low_mask;
  // Digits below the current one are all zero: jump straight to the end.
  assign low_mask = (H'(1) << (cnt * D)) - H'(1);
  assign last     = (((be | bo) & low_mask) == '0);
  assign skip_sh  = last ? 7'(cnt * D) : 7'd0;
`else
  assign last     = (cnt == '0);
  assign skip_sh  = 7'd0;
`endif

  gf2_digit_mac u_mac_ee (.x(ae), .digit(dig_e), .acc(acc_ee), .acc_next(mac_ee));
  gf2_digit_mac u_mac_eo (.x(ae), .digit(dig_o), .acc(acc_eo), .acc_next(mac_eo));
  gf2_digit_mac u_mac_oe (.x(ao), .digit(dig_e), .acc(acc_oe), .acc_next(mac_oe));
  gf2_digit_mac u_mac_oo (.x(ao), .digit(dig_o), .acc(acc_oo), .acc_next(mac_oo));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MUL;
      end
      MUL: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ae     <= '0;
      ao     <= '0;
      be     <= '0;
      bo     <= '0;
      acc_ee <= '0;
      acc_eo <= '0;
      acc_oe <= '0;
      acc_oo <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            ae     <= split_even(a_in);
            ao     <= split_odd(a_in);
            be     <= split_even(b_in);
            bo     <= split_odd(b_in);
            acc_ee <= '0;
            acc_eo <= '0;
            acc_oe <= '0;
            acc_oo <= '0;
            cnt    <= CW'(ND - 1);
          end
        end
        MUL: begin
          acc_ee <= mac_ee << skip_sh;
          acc_eo <= mac_eo << skip_sh;
          acc_oe <= mac_oe << skip_sh;
          acc_oo <= mac_oo << skip_sh;
          cnt    <= last ? '0 : cnt - CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign p_ee = acc_ee;
  assign p_eo = acc_eo;
  assign p_oe = acc_oe;
  assign p_oo = acc_oo;

endmodule

`default_nettype wire

// File: tb/tb_obs_split_mul_71bit.sv
// ============================================================================
// tb_obs_split_mul_71bit : directed vector table plus handshake/reset sequences
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_obs_split_mul_71bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [70:0] a_in, b_in, p_ee, p_eo, p_oe, p_oo;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  obs_split_mul_71bit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .p_ee(p_ee), .p_eo(p_eo), .p_oe(p_oe), .p_oo(p_oo)
  );

  typedef struct {
    logic [70:0] a, b, ee, eo, oe, oo;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [70:0] act, input logic [70:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] half(input logic [70:0] v, input int odd);
    logic [35:0] r = '0;
    for (int k = 0; k < 36; k++) if (2*k + odd < 71) r[k] = v[2*k+odd];
    return r;
  endfunction

  function automatic logic [70:0] clmul(input logic [35:0] x, input logic [35:0] y);
    logic [70:0] r = '0;
    for (int i = 0; i < 36; i++) if (y[i]) r = r ^ (71'(x) << i);
    return r;
  endfunction

  task automatic run_op(input logic [70:0] a, input logic [70:0] b, output int lat);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    a_in = a; b_in = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int          lat;
    int          guard;
    logic        stable;
    logic [70:0] ra, rb;
    logic [95:0] t96;

    vecs[0] = '{71'd1, 71'd1, 71'd1, 71'd0, 71'd0, 71'd0, 10};
    vecs[1] = '{71'd2, 71'd2, 71'd0, 71'd0, 71'd0, 71'd1, 10};
    vecs[2] = '{{71{1'b1}}, 71'd1, 71'h0F_FFFF_FFFF, 71'd0, 71'h07_FFFF_FFFF, 71'd0, 10};
    vecs[3] = '{71'd5, 71'd5, 71'd5, 71'd0, 71'd0, 71'd0, 10};
    vecs[4] = '{71'd2, 71'd1, 71'd0, 71'd0, 71'd1, 71'd0, 10};
`ifdef OBS_SPLIT_MUL_ZERO_SKIP_EN
    vecs[5] = '{71'd1, 71'd1 << 70, 71'h8_0000_0000, 71'd0, 71'd0, 71'd0, 2};
`else
    vecs[5] = '{71'd1, 71'd1 << 70, 71'h8_0000_0000, 71'd0, 71'd0, 71'd0, 10};
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 71'(in_ready), 71'd1);
    chk("reset_out_valid", 71'(out_valid), 71'd0);
    chk("reset_p_ee", p_ee, 71'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), 71'(lat), 71'(vecs[i].lat));
      chk($sformatf("v%0d_p_ee", i), p_ee, vecs[i].ee);
      chk($sformatf("v%0d_p_eo", i), p_eo, vecs[i].eo);
      chk($sformatf("v%0d_p_oe", i), p_oe, vecs[i].oe);
      chk($sformatf("v%0d_p_oo", i), p_oo, vecs[i].oo);
      release_out();
    end

    // Backpressure: results and handshake frozen while a new request waits.
    run_op(71'd5, 71'd5, lat);
    a_in = 71'd3; b_in = 71'd3; in_valid = 1'b1;
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (p_ee !== 71'd5 || p_eo !== 71'd0 || p_oe !== 71'd0 || p_oo !== 71'd0 ||
          out_valid !== 1'b1 || in_ready !== 1'b0) stable = 1'b0;
    end
    chk("bp_stable", 71'(stable), 71'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release_out_valid", 71'(out_valid), 71'd0);
    chk("bp_release_in_ready", 71'(in_ready), 71'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_accepted", 71'(in_ready), 71'd0);
    guard = 0;
    while (!out_valid && guard < 100) begin
      @(posedge clk); #1; guard++;
    end
    chk("bp_second_p_ee", p_ee, 71'd1);
    chk("bp_second_p_oo", p_oo, 71'd1);
    release_out();

    // Reset during the fourth MUL cycle.
    a_in = 71'd1; b_in = 71'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("abort_in_ready_async", 71'(in_ready), 71'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_out_valid", 71'(out_valid), 71'd0);
    chk("abort_in_ready", 71'(in_ready), 71'd1);
    chk("abort_p_ee_cleared", p_ee, 71'd0);
    run_op(71'd3, 71'd3, lat);
    chk("post_abort_p_ee", p_ee, 71'd1);
    chk("post_abort_p_eo", p_eo, 71'd1);
    chk("post_abort_p_oe", p_oe, 71'd1);
    chk("post_abort_p_oo", p_oo, 71'd1);
    release_out();

    for (int r = 0; r < 6; r++) begin
      t96 = {$urandom, $urandom, $urandom}; ra = t96[70:0];
      t96 = {$urandom, $urandom, $urandom}; rb = t96[70:0];
      run_op(ra, rb, lat);
      chk($sformatf("rnd%0d_p_ee", r), p_ee, clmul(half(ra, 0), half(rb, 0)));
      chk($sformatf("rnd%0d_p_eo", r), p_eo, clmul(half(ra, 0), half(rb, 1)));
      chk($sformatf("rnd%0d_p_oe", r), p_oe, clmul(half(ra, 1), half(rb, 0)));
      chk($sformatf("rnd%0d_p_oo", r), p_oo, clmul(half(ra, 1), half(rb, 1)));
      chk($sformatf("rnd%0d_top_bits", r), 71'({p_eo[70], p_oe[70], p_oo[70:69]}), 71'd0);
      release_out();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/obs_split_mul_71bit.md
Name: obs_split_mul_71bit

Overview:
- Upstream producer for the 71-bit OBS overlap stage of the 283-bit GF(2)[x] multiplier (L4 level).
- Accepts two 71-bit binary polynomials A, B and splits each into even-index and odd-index coefficient halves: Ae/Be 36 bits, Ao/Bo 35 bits.
- Computes the four carry-less half products with a digit-serial MSB-first engine: p_ee=Ae*Be, p_eo=Ae*Bo, p_oe=Ao*Be, p_oo=Ao*Bo.
- Presents the four products as 71-bit words in the order the overlap stage expects (in1..in4 = ee, eo, oe, oo).

Parameters:
- W, 71, operand width (coefficients 0..W-1).
- H, 36, half width = ceil(W/2); odd half is zero-padded to H.
- D, 4, digit size in bits of the B halves consumed per MUL cycle; H mod D must be 0.
- PW, 71, product width = 2*H-1.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a_in  input  W  operand A, bit i = coeff of x^i
- b_in  input  W  operand B
- out_valid  output  1  products valid
- out_ready  input  1  downstream accepts products
- p_ee  output  PW  Ae*Be -> overlap in1
- p_eo  output  PW  Ae*Bo -> overlap in2
- p_oe  output  PW  Ao*Be -> overlap in3
- p_oo  output  PW  Ao*Bo -> overlap in4

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high. rst forces state IDLE, in_ready=1, out_valid=0, all product and accumulator registers 0, digit counter 0.
- Split: Ae[k]=A[2k] for k=0..35; Ao[k]=A[2k+1] for k=0..34; Ao[35]=0. Same rule for B.
- IDLE: in_ready=1. On in_valid&in_ready, latch Ae, Ao, Be, Bo, clear the four accumulators, set cnt=H/D-1, go to MUL.
- MUL: one cycle per digit, MSB digit first; in_ready=0, out_valid=0.
  - For each X in {Ae,Ao} and Y in {Be,By=Bo}: acc_XY <= (acc_XY << D) ^ XOR over j<D of (X << j) when digit bit j of Y is 1.
  - All four accumulators update in parallel; arithmetic is GF(2) (XOR only); accumulator width PW, no truncation occurs.
  - cnt decrements; when cnt==0 the update completes and the state goes to DONE.
- DONE: out_valid=1 and products held stable. On out_ready, go to IDLE with out_valid=0 next cycle. No new operand is accepted in the same cycle (in_ready stays 0 in DONE).
- Latency (D=4): accept at edge T; MUL during cycles T+1..T+9; out_valid high from T+10. Throughput is one result per 11 cycles minimum.
- Boundary cases:
  - out_ready held low: products and out_valid hold indefinitely.
  - in_valid while busy is ignored; the source must hold its operands.
  - rst mid-MUL or in DONE: immediate abort to the reset state; partial result discarded.
  - Bits p_eo[70] and p_oe[70] are always 0; p_oo[70:69] are always 0.

Optional Feature:
- Macro: OBS_SPLIT_MUL_ZERO_SKIP_EN.
- Defined: in MUL, if all remaining lower digits of both Be and Bo are zero, each acc is shifted left by (remaining digits)*D in one cycle and the state goes to DONE. Latency shrinks accordingly (minimum 1 MUL cycle); results are bit-identical.
- Undefined: fixed H/D MUL cycles.

Decomposition:
- Package obs_mul_pkg: W, H, D, PW constants; state enum {IDLE, MUL, DONE}; function split_even / split_odd.
- One natural sub-module: gf2_digit_mac (H-bit X times D-bit digit, XOR into shifted PW accumulator), instantiated four times.

Test Plan:
- A=1, B=1 -> p_ee=1; p_eo=p_oe=p_oo=0; out_valid exactly 10 cycles after accept (zero-skip off).
- A=2 (x), B=2 -> p_oo=1; the other three products are 0.
- A=all-ones (71 bits), B=1 -> p_ee=36'hF_FFFF_FFFF, p_oe=35 ones (35'h7_FFFF_FFFF), p_eo=p_oo=0.
- Backpressure: hold out_ready=0 for 20 cycles after out_valid -> products stable, in_ready=0, second in_valid ignored; release -> IDLE, then second operand is accepted.
- Assert rst at MUL cycle 4 -> out_valid=0 and in_ready=1 after reset is released. Then A=3, B=3 -> p_ee=1, p_eo=1, p_oe=1, p_oo=1.
- Zero-skip build: A=1, B=x^70 (Be[35]) -> p_ee=x^35 with out_valid 2 cycles after accept. Plus 1000 random pairs checked against a bit-serial reference, and the recombined overlap output checked against the full 141-bit product.
